adder: RTL and testbench
========================

ADDER -- requirements
Module: adder

Interface
REQ-001 Parameter: WIDTH, 4, operand/sum bit width; SHALL support any value >= 1, with a multiple of 4 as the primary use.
REQ-002 Port: clk  input  1  sole clock; all state SHALL update on its rising edge only.
REQ-003 Port: rst  input  1  reset; it SHALL be synchronous and active-high.
REQ-004 Port: a  input  WIDTH  operand A, unsigned or two's complement.
REQ-005 Port: b  input  WIDTH  operand B, unsigned or two's complement.
REQ-006 Port: c_in  input  1  carry into bit 0.
REQ-007 Port: in_valid  input  1  qualifies a/b/c_in in the current cycle.
REQ-008 Port: c_out  output  1  registered carry out of bit WIDTH-1.
REQ-009 Port: sum  output  WIDTH  registered low WIDTH bits of a+b+c_in.
REQ-010 Port: ovf  output  1  registered two's-complement overflow flag.
REQ-011 Port: out_valid  output  1  registered; high when c_out/sum/ovf hold a new result.
REQ-012 Data ports SHALL follow clk, rst in the order a, b, c_in, c_out, sum, then in_valid, ovf, out_valid.

Function
REQ-013 {c_out, sum} SHALL equal the full (WIDTH+1)-bit result of a + b + c_in, with all three operands zero-extended.
REQ-014 ovf SHALL be (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]), i.e. carry into MSB XOR carry out of MSB.
REQ-015 Latency SHALL be exactly 1 cycle: inputs sampled at edge N appear on the outputs after edge N.
REQ-016 A result SHALL be captured only when in_valid=1. When in_valid=0, c_out, sum and ovf SHALL hold their previous values.
REQ-017 out_valid SHALL be in_valid delayed by one cycle. It SHALL be a single-cycle pulse per accepted input, and SHALL stay high on back-to-back inputs.
REQ-018 The datapath SHALL be carry-lookahead in 4-bit groups:
- per-bit generate g=a&b and propagate p=a^b;
- group carries computed from g/p;
- group carry rippling between groups;
- a final partial group when WIDTH is not a multiple of 4.
REQ-019 The combinational path from inputs to the output registers SHALL contain no latches and no feedback loops.
REQ-020 Boundary, all-ones with carry: a=b=all ones, c_in=1 -> sum=all ones, c_out=1.
REQ-021 Boundary, carry into zero: a=all ones, b=0, c_in=1 -> sum=0, c_out=1, ovf=0.
REQ-022 Inputs changing in cycles where in_valid=0 SHALL have no effect on any output.

Reset
REQ-023 While rst=1 at a rising edge: sum=0, c_out=0, ovf=0, out_valid=0 after that edge.
REQ-024 rst SHALL take priority over in_valid. An input presented in the same cycle as reset SHALL be discarded and SHALL produce no out_valid pulse.
REQ-025 Reset asserted mid-stream SHALL cancel any pending result. The first valid input after rst deasserts SHALL produce out_valid exactly one cycle later.
REQ-026 Outputs are undefined before the first reset; the bench SHALL apply rst for at least 1 cycle at start.

Verification
REQ-027 Zero case, WIDTH=4: a=0, b=0, c_in=0, in_valid=1 -> next cycle sum=0, c_out=0, ovf=0, out_valid=1.
REQ-028 Doubled-operand case, WIDTH=4: a=9, b=9, c_in=1 -> sum=3, c_out=1, ovf=1.
REQ-029 Signed overflow, WIDTH=4:
- a=7, b=1, c_in=0 -> sum=8, c_out=0, ovf=1;
- a=8, b=8, c_in=0 -> sum=0, c_out=1, ovf=1.
REQ-030 Hold: one valid input a=3, b=4, then in_valid=0 with a=F, b=F -> sum stays 7, out_valid=1 for one cycle then 0.
REQ-031 Reset mid-stream: in_valid=1 every cycle with rst=1 pulsed for one cycle -> after that edge all outputs are 0 and out_valid=0; valid results resume one cycle after rst=0.
REQ-032 Random check: at least 1000 random valid inputs at WIDTH=4 and WIDTH=13, each output compared against a+b+c_in computed one cycle earlier.

Source files
------------

// File: rtl/adder.sv
// Registered WIDTH-bit adder with carry-in, carry-out and signed overflow.
// Sums use carry-lookahead inside 4-bit groups, with the group carry rippling between groups.
module adder #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             c_out,
    output logic [WIDTH-1:0] sum,
    input  logic             in_valid,
    output logic             ovf,
    output logic             out_valid
);

    localparam int unsigned GRP  = 4;
    localparam int unsigned NGRP = (WIDTH + GRP - 1) / GRP;
    localparam int unsigned MSB  = WIDTH - 1;

    // Carry into bit k of a 4-bit group (k = 4 is the group carry out), two-level form.
    function automatic logic cla_carry(input logic [3:0] g4, input logic [3:0] p4,
                                       input logic cin, input int unsigned k);
        logic c;
        case (k)
            0: c = cin;
            1: c = g4[0] | (p4[0] & cin);
            2: c = g4[1] | (p4[1] & g4[0]) | (&p4[1:0] & cin);
            3: c = g4[2] | (p4[2] & g4[1]) | (&p4[2:1] & g4[0]) | (&p4[2:0] & cin);
            default: c = g4[3] | (p4[3] & g4[2]) | (&p4[3:2] & g4[1])
                       | (&p4[3:1] & g4[0]) | (&p4 & cin);
        endcase
        return c;
    endfunction

    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] sum_c;
    logic             c_out_c;
    logic             ovf_c;

    assign g = a & b;
    assign p = a ^ b;

    for (genvar gi = 0; gi < NGRP; gi++) begin : g_grp
        localparam int unsigned LO = gi * GRP;
        localparam int unsigned GW = (WIDTH - LO >= GRP) ? GRP : WIDTH - LO;

        logic          cin;
        logic          cout;
        logic [3:0]    g4;
        logic [3:0]    p4;
        logic [GW-1:0] cb;

        if (gi == 0) begin : g_first
            assign cin = c_in;
        end else begin : g_next
            assign cin = g_grp[gi-1].cout;
        end

        // A short final group is zero-padded so its unused lanes neither generate nor propagate.
        assign g4 = 4'(g[LO +: GW]);
        assign p4 = 4'(p[LO +: GW]);

        for (genvar j = 0; j < GW; j++) begin : g_bit
            assign cb[j] = cla_carry(g4, p4, cin, j);
        end

        assign cout            = cla_carry(g4, p4, cin, GW);
        assign sum_c[LO +: GW] = p[LO +: GW] ^ cb;
    end

    assign c_out_c = g_grp[NGRP-1].cout;
    assign ovf_c   = (a[MSB] == b[MSB]) && (sum_c[MSB] != a[MSB]);

    logic [WIDTH-1:0] sum_d, sum_q;
    logic             c_out_d, c_out_q;
    logic             ovf_d, ovf_q;
    logic             out_valid_d, out_valid_q;

    // Results are captured only for qualified inputs; otherwise the last result is held.
    always_comb begin
        sum_d       = sum_q;
        c_out_d     = c_out_q;
        ovf_d       = ovf_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            sum_d   = sum_c;
            c_out_d = c_out_c;
            ovf_d   = ovf_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q       <= '0;
            c_out_q     <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            sum_q       <= sum_d;
            c_out_q     <= c_out_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign sum       = sum_q;
    assign c_out     = c_out_q;
    assign ovf       = ovf_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_adder.sv
// Bench for adder at WIDTH=4 and WIDTH=13: arithmetic reference model plus directed literal checks.
module tb_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        c_in;
    logic        in_valid;
    logic [3:0]  a4, b4, sum4;
    logic [12:0] a13, b13, sum13;
    logic        c_out4, ovf4, out_valid4;
    logic        c_out13, ovf13, out_valid13;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    adder #(.WIDTH(4)) u_add4 (
        .clk(clk), .rst(rst), .a(a4), .b(b4), .c_in(c_in), .c_out(c_out4), .sum(sum4),
        .in_valid(in_valid), .ovf(ovf4), .out_valid(out_valid4)
    );

    adder #(.WIDTH(13)) u_add13 (
        .clk(clk), .rst(rst), .a(a13), .b(b13), .c_in(c_in), .c_out(c_out13), .sum(sum13),
        .in_valid(in_valid), .ovf(ovf13), .out_valid(out_valid13)
    );

    // Reference: integer sum for unsigned result, signed range test for overflow.
    function automatic void ref_add(input int w, input int av, input int bv, input int ci,
                                    output int s, output int co, output int ov);
        int full, sa, sb, ssum, half;
        half = 1 << (w - 1);
        full = av + bv + ci;
        s    = full & ((1 << w) - 1);
        co   = (full >> w) & 1;
        sa   = (av >= half) ? av - (1 << w) : av;
        sb   = (bv >= half) ? bv - (1 << w) : bv;
        ssum = sa + sb + ci;
        ov   = (ssum > half - 1 || ssum < -half) ? 1 : 0;
    endfunction

    int m_sum4, m_co4, m_ov4, m_sum13, m_co13, m_ov13, m_vld;
    bit armed = 1'b0;

    always @(posedge clk) begin
        int s, co, ov;
        if (rst) begin
            armed   <= 1'b1;
            m_vld   <= 0;
            m_sum4  <= 0; m_co4  <= 0; m_ov4  <= 0;
            m_sum13 <= 0; m_co13 <= 0; m_ov13 <= 0;
        end else begin
            m_vld <= int'(in_valid);
            if (in_valid) begin
                ref_add(4, int'(a4), int'(b4), int'(c_in), s, co, ov);
                m_sum4 <= s; m_co4 <= co; m_ov4 <= ov;
                ref_add(13, int'(a13), int'(b13), int'(c_in), s, co, ov);
                m_sum13 <= s; m_co13 <= co; m_ov13 <= ov;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison of both instances against the model once reset has been seen.
    always @(negedge clk) begin
        if (armed) begin
            check("w4_valid",  int'(out_valid4),  m_vld);
            check("w4_sum",    int'(sum4),        m_sum4);
            check("w4_cout",   int'(c_out4),      m_co4);
            check("w4_ovf",    int'(ovf4),        m_ov4);
            check("w13_valid", int'(out_valid13), m_vld);
            check("w13_sum",   int'(sum13),       m_sum13);
            check("w13_cout",  int'(c_out13),     m_co13);
            check("w13_ovf",   int'(ovf13),       m_ov13);
        end
    end

    task automatic drive(input logic v, input logic [3:0] av, input logic [3:0] bv, input logic ci);
        in_valid = v;
        a4       = av;
        b4       = bv;
        c_in     = ci;
        a13      = 13'($urandom);
        b13      = 13'($urandom);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic lit4(input string name, input int s, input int co, input int ov, input int v);
        check({name, "_sum"},   int'(sum4),       s);
        check({name, "_cout"},  int'(c_out4),     co);
        check({name, "_ovf"},   int'(ovf4),       ov);
        check({name, "_valid"}, int'(out_valid4), v);
    endtask

    initial begin
        rst = 1'b1;
        // Valid inputs under reset must be discarded.
        drive(1'b1, 4'h5, 4'h6, 1'b1);
        lit4("reset0", 0, 0, 0, 0);
        drive(1'b1, 4'h9, 4'h9, 1'b1);
        lit4("reset1", 0, 0, 0, 0);
        rst = 1'b0;

        drive(1'b1, 4'h0, 4'h0, 1'b0); lit4("zero", 0, 0, 0, 1);
        drive(1'b1, 4'h9, 4'h9, 1'b1); lit4("dbl9", 3, 1, 1, 1);
        drive(1'b1, 4'h7, 4'h1, 1'b0); lit4("ovf_pos", 8, 0, 1, 1);
        drive(1'b1, 4'h8, 4'h8, 1'b0); lit4("ovf_neg", 0, 1, 1, 1);
        drive(1'b1, 4'hF, 4'hF, 1'b1); lit4("ones_c", 15, 1, 0, 1);
        drive(1'b1, 4'hF, 4'h0, 1'b1); lit4("wrap0", 0, 1, 0, 1);

        // WIDTH=13 carry-into-zero boundary, run through the full group chain.
        in_valid = 1'b1; a13 = 13'h1FFF; b13 = 13'h0000; c_in = 1'b1; a4 = 4'h2; b4 = 4'h2;
        @(posedge clk); @(negedge clk);
        check("w13_wrap_sum",  int'(sum13),   0);
        check("w13_wrap_cout", int'(c_out13), 1);
        check("w13_wrap_ovf",  int'(ovf13),   0);
        in_valid = 1'b1; a13 = 13'h0FFF; b13 = 13'h0000; c_in = 1'b1;
        @(posedge clk); @(negedge clk);
        check("w13_ovf_sum", int'(sum13), 32'h1000);
        check("w13_ovf_ovf", int'(ovf13), 1);

        // Hold while in_valid is low, even with changing operands.
        drive(1'b1, 4'h3, 4'h4, 1'b0); lit4("hold_load", 7, 0, 0, 1);
        drive(1'b0, 4'hF, 4'hF, 1'b1); lit4("hold_1", 7, 0, 0, 0);
        drive(1'b0, 4'h8, 4'hC, 1'b0); lit4("hold_2", 7, 0, 0, 0);

        // Reset pulse mid-stream.
        drive(1'b1, 4'h2, 4'h5, 1'b0); lit4("pre_rst", 7, 0, 0, 1);
        rst = 1'b1;
        drive(1'b1, 4'h6, 4'h6, 1'b0); lit4("mid_rst", 0, 0, 0, 0);
        rst = 1'b0;
        drive(1'b1, 4'h1, 4'h1, 1'b1); lit4("post_rst", 3, 0, 0, 1);

        // Random back-to-back valid stream, then random gaps.
        for (int i = 0; i < 1200; i++)
            drive(1'b1, 4'($urandom), 4'($urandom), 1'($urandom));
        for (int i = 0; i < 300; i++)
            drive(1'($urandom_range(0, 3) != 0), 4'($urandom), 4'($urandom), 1'($urandom));

        drive(1'b0, 4'h0, 4'h0, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
